// File: rtl/i2c_pixel_loader_if.sv
// Byte-stream in / colour-memory write out bundle for the pixel loader.
// slave: the loader itself; master: the side that feeds bytes and consumes writes.
interface i2c_pixel_loader_if #(
  parameter int IDX_W = 8
);
  logic [7:0]       data;
  logic             data_valid;
  logic             start;
  logic             stop;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [23:0]      wr_data;
  logic             update;
  logic             err;

  modport slave (
    input  data, data_valid, start, stop,
    output wr_en, wr_addr, wr_data, update, err
  );

  modport master (
    output data, data_valid, start, stop,
    input  wr_en, wr_addr, wr_data, update, err
  );
endinterface

// File: rtl/i2c_pixel_loader.sv
// Turns an I2C write transaction (index byte, then 3-byte RGB pixels) into
// single-cycle colour-memory writes, with an update strobe after STOP when at
// least one pixel landed.
module i2c_pixel_loader #(
  parameter int NUM_LEDS = 8,
  parameter int IDX_W    = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  i2c_pixel_loader_if.slave   io_bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_INDEX   = 2'd1,
    ST_PIXEL   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // 9-bit compare so NUM_LEDS=256 accepts every index byte
  localparam logic [8:0]       LP_NUM  = 9'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LP_LAST = IDX_W'(NUM_LEDS - 1);

  state_t           r_state, w_state_next;
  logic [1:0]       r_cnt, w_cnt_next;
  logic [IDX_W-1:0] r_ptr, w_ptr_next;
  logic [15:0]      r_asm, w_asm_next;     // first two bytes of the pixel in flight
  logic             r_written, w_written_next;
  logic             r_wr_en, w_wr_en_next;
  logic [IDX_W-1:0] r_wr_addr, w_wr_addr_next;
  logic [23:0]      r_wr_data, w_wr_data_next;
  logic             r_update, w_update_next;
  logic             r_err, w_err_next;

  // State and output registers; reset returns to IDLE with every output low
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 2'd0;
      r_ptr     <= '0;
      r_asm     <= 16'd0;
      r_written <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 24'd0;
      r_update  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_ptr     <= w_ptr_next;
      r_asm     <= w_asm_next;
      r_written <= w_written_next;
      r_wr_en   <= w_wr_en_next;
      r_wr_addr <= w_wr_addr_next;
      r_wr_data <= w_wr_data_next;
      r_update  <= w_update_next;
      r_err     <= w_err_next;
    end
  end

  // Next-state logic: start overrides everything; otherwise the byte is
  // consumed first and a coincident stop then closes the transaction
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_ptr_next     = r_ptr;
    w_asm_next     = r_asm;
    w_written_next = r_written;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = r_wr_addr;
    w_wr_data_next = r_wr_data;
    w_update_next  = 1'b0;
    w_err_next     = r_err;

    if (io_bus.start) begin
      w_state_next   = ST_INDEX;
      w_cnt_next     = 2'd0;
      w_written_next = 1'b0;
      w_err_next     = 1'b0;
    end else begin
      if (io_bus.data_valid) begin
        case (r_state)
          ST_INDEX: begin
            if ({1'b0, io_bus.data} < LP_NUM) begin
              w_ptr_next   = IDX_W'(io_bus.data);
              w_state_next = ST_PIXEL;
            end else begin
              w_err_next   = 1'b1;
              w_state_next = ST_DISCARD;
            end
          end
          ST_PIXEL: begin
            w_asm_next = {r_asm[7:0], io_bus.data};
            if (r_cnt == 2'd2) begin
              w_wr_en_next   = 1'b1;
              w_wr_addr_next = r_ptr;
              w_wr_data_next = {r_asm, io_bus.data};
              w_cnt_next     = 2'd0;
              w_written_next = 1'b1;
              w_ptr_next     = (r_ptr == LP_LAST) ? '0 : r_ptr + IDX_W'(1);
            end else begin
              w_cnt_next = r_cnt + 2'd1;
            end
          end
          default: ;
        endcase
      end

      if (io_bus.stop) begin
        w_state_next   = ST_IDLE;
        w_cnt_next     = 2'd0;
        w_update_next  = w_written_next;
        w_written_next = 1'b0;
      end
    end
  end

  assign io_bus.wr_en   = r_wr_en;
  assign io_bus.wr_addr = r_wr_addr;
  assign io_bus.wr_data = r_wr_data;
  assign io_bus.update  = r_update;
  assign io_bus.err     = r_err;

endmodule

// File: doc/i2c_pixel_loader.md
Name: i2c_pixel_loader

Overview:
- Downstream consumer of the I2C slave byte stream (data, data_valid_o, start, stop) in the LED controller.
- Interprets each write transaction as:
  - one pixel-index byte;
  - then 24-bit pixels, sent as 3 bytes each.
- Emits single-cycle writes into the LED colour memory.
- Pulses an update strobe at transaction end so the LED driver can refresh.

Parameters:
- NUM_LEDS, 8, number of pixels in colour memory; valid range 1..256.
- IDX_W, 8, width of wr_addr; must satisfy 2^IDX_W >= NUM_LEDS.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data  input  8  received byte from I2C slave; valid only while data_valid is high.
- data_valid  input  1  1-cycle strobe per received data byte. The slave has already filtered out the address byte.
- start  input  1  1-cycle strobe on START or repeated START.
- stop  input  1  1-cycle strobe on STOP.
- wr_en  output  1  1-cycle colour-memory write strobe.
- wr_addr  output  IDX_W  pixel index being written.
- wr_data  output  24  pixel value; first received byte sits in [23:16], second in [15:8], third in [7:0].
- update  output  1  1-cycle strobe: transaction finished with at least one pixel written.
- err  output  1  sticky: index byte >= NUM_LEDS was received; cleared by the next start.

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, update=0, err=0.
  - Byte counter=0, pixel pointer=0, written flag=0.
- States:
  - IDLE: waiting for start. data_valid is ignored here.
  - INDEX: next byte is the pixel pointer.
  - PIXEL: bytes are assembled into pixels.
  - DISCARD: bytes are ignored until stop or start.
- Any state, start=1:
  - Go to INDEX.
  - Clear byte counter, written flag and err.
  - A data_valid in the same cycle is dropped; start has priority.
- INDEX, data_valid=1:
  - If data < NUM_LEDS: pointer <= data, go to PIXEL.
  - Otherwise: err <= 1, go to DISCARD.
- PIXEL, data_valid=1:
  - Byte shifts into the 24-bit assembly register; byte counter increments 0→1→2.
  - On the third byte (counter=2):
    - next cycle wr_en=1, wr_addr=pointer, wr_data=assembled pixel;
    - counter <= 0, written flag <= 1;
    - pointer <= (pointer == NUM_LEDS-1) ? 0 : pointer+1, i.e. wrap-around.
  - Latency: third data_valid to wr_en is exactly 1 cycle.
- stop=1 in any state:
  - Next state IDLE.
  - If a data_valid arrives in the same cycle, that byte is processed first (it can complete a pixel, whose write is still issued).
  - Any incomplete pixel (counter 1 or 2 after this cycle) is discarded; no write.
  - update=1 for one cycle, on the cycle after stop, if the written flag (including a write completed in the stop cycle) is set. The flag is then cleared.
- Repeated start during PIXEL:
  - Partial pixel discarded.
  - No update pulse; only stop generates update.
- wr_addr/wr_data hold their last values between writes.
- wr_en and update are never asserted in the same cycle except when a write completes in the stop cycle: wr_en and update then both assert on the following cycle.
- Reset mid-transaction: immediate return to IDLE; no write or update produced.
- Pointer arithmetic: IDX_W bits, wrap at NUM_LEDS, not at 2^IDX_W.

Test Plan:
- Reset, start, bytes 0x01, 0x70, 0x71, 0xA8, stop → one wr_en, wr_addr=1, wr_data=0x7071A8, 1 cycle after the 0xA8 strobe; update pulse 1 cycle after stop; err=0.
- start, 0x07, then 6 bytes 0x11..0x16, stop (NUM_LEDS=8) → writes addr 7 = 0x111213, then addr 0 = 0x141516 (wrap); single update.
- start, 0x02, 0xAA, 0xBB, stop → no wr_en, no update; the next transaction start, 0x03, 3 bytes → writes addr 3, unaffected by stale bytes.
- start, 0x09 (>= NUM_LEDS), 3 bytes, stop → err=1, no wr_en, no update; next start clears err to 0.
- start, 0x00, 0x01, 0x02, repeated start, 0x04, 0xC0, 0xC1, 0xC2, stop → only write: addr 4 = 0xC0C1C2; start coincident with a data_valid drops that byte; third byte coincident with stop → write still issued, then update.
- Assert reset after 2 of 3 pixel bytes → all outputs 0 immediately; subsequent bytes without start → no writes.
